// File: rtl/player_hit_gen_pkg.sv
// Shared game package: hit-generator FSM encoding, obstacle colour and HP-controller constants.
// Also holds the hitbox span test used for the collision check.
package player_hit_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HIT      = 2'd2,
    ST_COOLDOWN = 2'd3
  } hit_state_t;

  localparam logic [11:0] OBSTACLE_COLOR_DEF = 12'hf00;

  localparam int HP_MAX   = 3;
  localparam int HP_WIDTH = 2;

  // 13-bit sum so a hitbox running past 4095 never wraps to low coordinates
  function automatic logic in_span(input logic [11:0] pos, input logic [11:0] lo,
                                   input logic [12:0] size);
    logic [12:0] hi;
    hi = {1'b0, lo} + size;
    return ({1'b0, pos} >= {1'b0, lo}) && ({1'b0, pos} < hi);
  endfunction

endpackage

// File: rtl/player_hit_gen_frame_edge.sv
// Rising-edge detector on vblnk; the edge flag is valid on the first blanking cycle.
module frame_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic vblnk,
  output logic frame_edge
);

  logic vblnk_prev;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) vblnk_prev <= 1'b0;
    else      vblnk_prev <= vblnk;
  end

  assign frame_edge = vblnk & ~vblnk_prev;

endmodule

// File: rtl/player_hit_gen.sv
// Player/obstacle collision detector: one damage pulse per colliding frame, then a
// frame-counted invulnerability window. VGA timing and colour pass through one register.
//
// state    | meaning
// IDLE     | no game running, waiting for game_on
// ARMED    | collecting collisions, pulse on the next frame edge if any
// HIT      | single-cycle player_hit pulse
// COOLDOWN | invulnerable, counting down frame edges
module player_hit_gen
  import player_hit_gen_pkg::*;
#(
  parameter int          PLAYER_SIZE    = 20,
  parameter logic [11:0] OBSTACLE_COLOR = OBSTACLE_COLOR_DEF,
  parameter int          INVULN_FRAMES  = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  input  logic        game_on,
  input  logic        game_over,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        player_hit,
  output logic        invuln
);

  localparam logic [12:0] SIZE13     = 13'(PLAYER_SIZE);
  localparam logic [7:0]  INVULN_CNT = 8'(INVULN_FRAMES);

  hit_state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       collide, collide_nx;
  logic       frame_edge;
  logic       pix_hit;

  frame_edge_det u_edge (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk      (vblnk_in),
    .frame_edge (frame_edge)
  );

  assign pix_hit = !hblnk_in && !vblnk_in && (rgb_in == OBSTACLE_COLOR) &&
                   in_span(hcount_in, player_x, SIZE13) &&
                   in_span(vcount_in, player_y, SIZE13);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    collide_nx = collide | pix_hit;
    if (!game_on || game_over) begin
      state_nx   = ST_IDLE;
      cnt_nx     = '0;
      collide_nx = 1'b0;
    end else begin
      if (frame_edge) collide_nx = 1'b0;
      case (state)
        ST_IDLE:  state_nx = ST_ARMED;
        ST_ARMED: if (frame_edge && collide) state_nx = ST_HIT;
        ST_HIT: begin
          state_nx = ST_COOLDOWN;
          cnt_nx   = INVULN_CNT;
        end
        ST_COOLDOWN: begin
          // the frame ending at the final edge is still invulnerable: its collide is dropped
          if (frame_edge) begin
            if (cnt <= 8'd1) begin
              cnt_nx   = '0;
              state_nx = ST_ARMED;
            end else begin
              cnt_nx = cnt - 8'd1;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      collide    <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      collide    <= collide_nx;
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= rgb_in;
    end
  end

  assign player_hit = (state == ST_HIT);
  assign invuln     = (state == ST_COOLDOWN);

endmodule

// File: tb/tb_player_hit_gen.sv
// Directed bench for player_hit_gen: a vector table of single-pixel frames plus
// hand-written sequences for cooldown spacing, abort, and asynchronous reset.
module tb_player_hit_gen;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, rgb_in, player_x, player_y;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, game_on, game_over;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, player_hit, invuln;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  always #5 pclk = ~pclk;

  player_hit_gen #(
    .PLAYER_SIZE    (20),
    .OBSTACLE_COLOR (12'hf00),
    .INVULN_FRAMES  (3)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .player_x   (player_x),
    .player_y   (player_y),
    .game_on    (game_on),
    .game_over  (game_over),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out),
    .player_hit (player_hit),
    .invuln     (invuln)
  );

  typedef struct {
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] h;
    logic [11:0] v;
    logic [11:0] rgb;
    logic        hb;
    logic        exp_hit;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    if (player_hit) pulses++;
  endtask

  task automatic neutral();
    hcount_in = 12'd0;
    vcount_in = 12'd0;
    rgb_in    = 12'h000;
    hblnk_in  = 1'b0;
  endtask

  task automatic arm();
    game_on = 1'b0;
    tick();
    game_on = 1'b1;
    tick();
  endtask

  // active period with optional obstacle at (105,110), then vblank with the edge
  task automatic run_frame(input logic obst, output logic inv_mid);
    vblnk_in = 1'b0;
    neutral();
    tick();
    if (obst) begin
      hcount_in = 12'd105;
      vcount_in = 12'd110;
      rgb_in    = 12'hf00;
    end
    tick();
    neutral();
    inv_mid = invuln;
    tick();
    vblnk_in = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    logic inv;
    vt[0]  = '{12'd100,  12'd100,  12'd105,  12'd110,  12'hf00, 1'b0, 1'b1};
    vt[1]  = '{12'd100,  12'd100,  12'd120,  12'd100,  12'hf00, 1'b0, 1'b0};
    vt[2]  = '{12'd100,  12'd100,  12'd105,  12'd105,  12'hf01, 1'b0, 1'b0};
    vt[3]  = '{12'd100,  12'd100,  12'd119,  12'd119,  12'hf00, 1'b0, 1'b1};
    vt[4]  = '{12'd100,  12'd100,  12'd100,  12'd100,  12'hf00, 1'b0, 1'b1};
    vt[5]  = '{12'd100,  12'd100,  12'd99,   12'd105,  12'hf00, 1'b0, 1'b0};
    vt[6]  = '{12'd100,  12'd100,  12'd105,  12'd120,  12'hf00, 1'b0, 1'b0};
    vt[7]  = '{12'd100,  12'd100,  12'd105,  12'd110,  12'hf00, 1'b1, 1'b0};
    vt[8]  = '{12'd4090, 12'd100,  12'd2,    12'd105,  12'hf00, 1'b0, 1'b0};
    vt[9]  = '{12'd4090, 12'd100,  12'd4095, 12'd105,  12'hf00, 1'b0, 1'b1};
    vt[10] = '{12'd100,  12'd4090, 12'd105,  12'd3,    12'hf00, 1'b0, 1'b0};
    vt[11] = '{12'd100,  12'd4090, 12'd105,  12'd4093, 12'hf00, 1'b0, 1'b1};

    // reset with busy inputs: every output must be held at 0
    rst = 1'b0;
    hcount_in = 12'h123; vcount_in = 12'h456; rgb_in = 12'hfff;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
    player_x = 12'd100; player_y = 12'd100;
    game_on = 1'b1; game_over = 1'b0;
    #23;
    chk("rst_hcount", 32'(hcount_out), 32'h0);
    chk("rst_vcount", 32'(vcount_out), 32'h0);
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    chk("rst_sync_blnk", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    chk("rst_hit_inv", 32'({player_hit, invuln}), 32'h0);
    @(negedge pclk);
    rst = 1'b1;
    tick();
    chk("pass_rgb", 32'(rgb_out), 32'hfff);
    chk("pass_cnt", 32'({hcount_out, vcount_out}), 32'h123456);
    chk("pass_sync_blnk", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'hf);
    hsync_in = 1'b0; vsync_in = 1'b0;

    for (int i = 0; i < 12; i++) begin
      player_x = vt[i].px;
      player_y = vt[i].py;
      arm();
      pulses = 0;
      vblnk_in = 1'b0;
      neutral();
      tick();
      hcount_in = vt[i].h;
      vcount_in = vt[i].v;
      rgb_in    = vt[i].rgb;
      hblnk_in  = vt[i].hb;
      tick();
      chk($sformatf("vec%0d_rgb_out", i), 32'(rgb_out), 32'(vt[i].rgb));
      chk($sformatf("vec%0d_hcount_out", i), 32'(hcount_out), 32'(vt[i].h));
      neutral();
      tick();
      vblnk_in = 1'b1;
      tick();
      chk($sformatf("vec%0d_hit", i), 32'(player_hit), 32'(vt[i].exp_hit));
      tick();
      chk($sformatf("vec%0d_invuln", i), 32'(invuln), 32'(vt[i].exp_hit));
      chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vt[i].exp_hit));
    end

    // obstacle every frame, 3-frame cooldown: pulses 4 edges apart
    player_x = 12'd100; player_y = 12'd100;
    arm();
    for (int k = 0; k < 9; k++) begin
      pulses = 0;
      run_frame(1'b1, inv);
      chk($sformatf("cd_pulse_f%0d", k), 32'(pulses), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cd_invuln_f%0d", k), 32'(inv), (k % 4 == 0) ? 32'd0 : 32'd1);
    end

    // game_over on the frame-edge cycle with collide set
    arm();
    vblnk_in = 1'b0;
    neutral();
    tick();
    hcount_in = 12'd105; vcount_in = 12'd110; rgb_in = 12'hf00;
    tick();
    neutral();
    tick();
    pulses = 0;
    vblnk_in = 1'b1;
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    chk("go_edge_hit", 32'(player_hit), 32'h0);
    chk("go_edge_inv", 32'(invuln), 32'h0);
    tick();
    tick();
    run_frame(1'b0, inv);
    chk("go_no_pulse", 32'(pulses), 32'h0);

    // game_on dropped mid-cooldown
    arm();
    pulses = 0;
    run_frame(1'b1, inv);
    chk("off_pulse", 32'(pulses), 32'h1);
    chk("off_inv_before", 32'(invuln), 32'h1);
    game_on = 1'b0;
    tick();
    chk("off_inv_after", 32'(invuln), 32'h0);
    game_on = 1'b1;

    // asynchronous reset mid-cooldown, then normal re-arm
    arm();
    run_frame(1'b1, inv);
    rgb_in = 12'habc; hcount_in = 12'd77;
    tick();
    chk("ar_inv_before", 32'(invuln), 32'h1);
    chk("ar_rgb_before", 32'(rgb_out), 32'habc);
    @(posedge pclk);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_inv", 32'(invuln), 32'h0);
    chk("ar_rgb", 32'(rgb_out), 32'h0);
    chk("ar_hcount", 32'(hcount_out), 32'h0);
    chk("ar_vblnk", 32'(vblnk_out), 32'h0);
    #2;
    rst = 1'b1;
    tick();
    pulses = 0;
    run_frame(1'b1, inv);
    chk("ar_rearm_inv", 32'(inv), 32'h0);
    chk("ar_rearm_pulse", 32'(pulses), 32'h1);
    chk("ar_rearm_cooldown", 32'(invuln), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
